keypad_conditioner: RTL and testbench

- Front-end stage between the raw 10-key keypad and the combination-lock controller.
- Synchronizes the asynchronous key lines and debounces them.
- Rejects simultaneous multi-key presses and emits exactly one registered single-cycle press strobe with its BCD digit per clean key press.
- The strobe replaces edge-triggered press detection downstream, so the lock samples digit/press on clk only.

---
 rtl/keypad_conditioner.sv | 143 ++++++++++++++
 tb/tb_keypad_conditioner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_conditioner.sv
// Keypad front end: two-flop synchronizer, debounce filter and single-key press FSM.
// Each clean key press gives one registered press strobe with its BCD digit.
module keypad_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       hard_rst,
    input  logic [9:0] keypad_raw,
    output logic       press,
    output logic [3:0] digit,
    output logic       held,
    output logic       multi_err,
    output logic [9:0] db_monitor
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        INVALID = 2'd2
    } state_t;

    logic [9:0]       sync1_q, sync2_q;
    logic [9:0]       cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic [9:0]       db_q;
    state_t           state_q, state_d;
    logic             press_q, press_d;
    logic             multi_q, multi_d;
    logic             held_q, held_d;
    logic [3:0]       digit_q, digit_d;

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [3:0] encode10(input logic [9:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [9:0] key_mask(input logic [3:0] d);
        return 10'd1 << d;
    endfunction

    // Synchronizer and debounce filter: db only takes a value sync held for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or posedge hard_rst) begin
        if (hard_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
        end else begin
            sync1_q <= keypad_raw;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q == CNT_MAX) begin
                db_q <= cand_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge hard_rst) begin
        if (hard_rst) begin
            state_q <= IDLE;
            press_q <= 1'b0;
            multi_q <= 1'b0;
            held_q  <= 1'b0;
            digit_q <= 4'd0;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
            multi_q <= multi_d;
            held_q  <= held_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        press_d = 1'b0;
        multi_d = 1'b0;
        held_d  = 1'b0;
        digit_d = digit_q;
        case (state_q)
            IDLE: begin
                if (db_q != '0) begin
                    if (popcount10(db_q) == 4'd1) begin
                        press_d = 1'b1;
                        held_d  = 1'b1;
                        digit_d = encode10(db_q);
                        state_d = PRESSED;
                    end else begin
                        multi_d = 1'b1;
                        state_d = INVALID;
                    end
                end
            end
            PRESSED: begin
                if (db_q == '0) begin
                    state_d = IDLE;
                end else if (db_q != key_mask(digit_q)) begin
                    // Key added or swapped without a release: never a new press
                    multi_d = (popcount10(db_q) > 4'd1);
                    state_d = INVALID;
                end else begin
                    held_d = 1'b1;
                end
            end
            INVALID: begin
                if (db_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign press      = press_q;
    assign multi_err  = multi_q;
    assign held       = held_q;
    assign digit      = digit_q;
    assign db_monitor = db_q;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed bench for keypad_conditioner: table of hold/release windows plus
// hand-written bounce, multi-key, swap and mid-press reset sequences.
module tb_keypad_conditioner;

    logic       clk = 1'b0;
    logic       hard_rst = 1'b0;
    logic [9:0] keypad_raw = '0;
    logic       press;
    logic [3:0] digit;
    logic       held;
    logic       multi_err;
    logic [9:0] db_monitor;

    int n_cmp = 0;
    int n_bad = 0;
    int n_both = 0;

    keypad_conditioner dut (
        .clk        (clk),
        .hard_rst   (hard_rst),
        .keypad_raw (keypad_raw),
        .press      (press),
        .digit      (digit),
        .held       (held),
        .multi_err  (multi_err),
        .db_monitor (db_monitor)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] raw;
        int         cycles;
        int         exp_np;
        int         exp_at;
        int         exp_nm;
        int         exp_digit;
        int         exp_held;
        int         exp_db;
        int         exp_dbor;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance one clock; returns at the following falling edge with outputs settled
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (press && multi_err) n_both++;
    endtask

    task automatic run(input int n, output int np, output int first, output int nm,
                       output logic [9:0] dbor);
        np = 0; first = -1; nm = 0; dbor = '0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (press) begin
                np++;
                if (first < 0) first = k;
            end
            if (multi_err) nm++;
            dbor = dbor | db_monitor;
        end
    endtask

    int np, first, nm;
    logic [9:0] dbor;
    int np_acc, nm_acc;

    initial begin
        tbl[0] = '{10'b0000100000, 40, 1, 20, 0, 5, 1, 32'h020, 32'h020};
        tbl[1] = '{10'b0000000000, 25, 0, -1, 0, 5, 0, 0,      32'h020};
        tbl[2] = '{10'b0000010000, 10, 0, -1, 0, 5, 0, 0,      0};
        tbl[3] = '{10'b0000000000, 25, 0, -1, 0, 5, 0, 0,      0};
        tbl[4] = '{10'b0000000010, 30, 1, 20, 0, 1, 1, 32'h002, 32'h002};
        tbl[5] = '{10'b0000000000, 25, 0, -1, 0, 1, 0, 0,      32'h002};

        // Reset state
        @(negedge clk);
        hard_rst = 1'b1;
        #1;
        chk("rst_press", int'(press), 0);
        chk("rst_held", int'(held), 0);
        chk("rst_multi", int'(multi_err), 0);
        chk("rst_digit", int'(digit), 0);
        chk("rst_db", int'(db_monitor), 0);
        @(negedge clk);
        @(negedge clk);
        hard_rst = 1'b0;

        // Table-driven windows
        for (int r = 0; r < 6; r++) begin
            keypad_raw = tbl[r].raw;
            run(tbl[r].cycles, np, first, nm, dbor);
            chk($sformatf("row%0d_npress", r), np, tbl[r].exp_np);
            chk($sformatf("row%0d_press_at", r), first, tbl[r].exp_at);
            chk($sformatf("row%0d_nmulti", r), nm, tbl[r].exp_nm);
            chk($sformatf("row%0d_digit", r), int'(digit), tbl[r].exp_digit);
            chk($sformatf("row%0d_held", r), int'(held), tbl[r].exp_held);
            chk($sformatf("row%0d_db", r), int'(db_monitor), tbl[r].exp_db);
            chk($sformatf("row%0d_db_seen", r), int'(dbor), tbl[r].exp_dbor);
        end

        // Bouncing key 9: three toggles 4 cycles apart, then stable
        np_acc = 0; nm_acc = 0;
        keypad_raw = 10'b1000000000;
        run(4, np, first, nm, dbor); np_acc += np; nm_acc += nm;
        keypad_raw = 10'b0000000000;
        run(4, np, first, nm, dbor); np_acc += np; nm_acc += nm;
        keypad_raw = 10'b1000000000;
        run(30, np, first, nm, dbor);
        chk("bounce_press_early", np_acc, 0);
        chk("bounce_npress", np, 1);
        chk("bounce_press_at", first, 20);
        chk("bounce_digit", int'(digit), 9);
        chk("bounce_nmulti", nm + nm_acc, 0);
        keypad_raw = '0;
        run(25, np, first, nm, dbor);
        chk("bounce_rel_held", int'(held), 0);

        // Keys 2 and 7 arriving 3 cycles apart: combined pattern only
        np_acc = 0; nm_acc = 0;
        keypad_raw = 10'b0000000100;
        run(3, np, first, nm, dbor); np_acc += np; nm_acc += nm;
        keypad_raw = 10'b0010000100;
        run(30, np, first, nm, dbor); np_acc += np; nm_acc += nm;
        chk("multi_nmulti", nm_acc, 1);
        chk("multi_npress", np_acc, 0);
        chk("multi_digit_kept", int'(digit), 9);
        chk("multi_held", int'(held), 0);
        chk("multi_db", int'(db_monitor), 32'h084);
        keypad_raw = '0;
        run(25, np, first, nm, dbor);
        chk("multi_rel_nmulti", nm, 0);
        keypad_raw = 10'b0000000010;
        run(30, np, first, nm, dbor);
        chk("after_multi_npress", np, 1);
        chk("after_multi_digit", int'(digit), 1);
        keypad_raw = '0;
        run(25, np, first, nm, dbor);

        // Key 3 accepted, then swapped straight to key 8
        keypad_raw = 10'b0000001000;
        run(30, np, first, nm, dbor);
        chk("swap_first_npress", np, 1);
        chk("swap_first_digit", int'(digit), 3);
        keypad_raw = 10'b0100000000;
        run(30, np, first, nm, dbor);
        chk("swap_npress", np, 0);
        chk("swap_nmulti", nm, 0);
        chk("swap_held", int'(held), 0);
        chk("swap_digit", int'(digit), 3);
        keypad_raw = '0;
        run(25, np, first, nm, dbor);
        chk("swap_rel_npress", np, 0);
        keypad_raw = 10'b0100000000;
        run(30, np, first, nm, dbor);
        chk("key8_npress", np, 1);
        chk("key8_press_at", first, 20);
        chk("key8_digit", int'(digit), 8);
        keypad_raw = '0;
        run(25, np, first, nm, dbor);

        // Reset asserted mid-cycle while key 6 is held and accepted
        keypad_raw = 10'b0001000000;
        run(30, np, first, nm, dbor);
        chk("k6_npress", np, 1);
        chk("k6_held", int'(held), 1);
        #2;
        hard_rst = 1'b1;
        #1;
        chk("midrst_held", int'(held), 0);
        chk("midrst_digit", int'(digit), 0);
        chk("midrst_db", int'(db_monitor), 0);
        chk("midrst_press", int'(press), 0);
        @(negedge clk);
        hard_rst = 1'b0;
        run(30, np, first, nm, dbor);
        chk("postrst_npress", np, 1);
        chk("postrst_press_at", first, 20);
        chk("postrst_digit", int'(digit), 6);
        chk("postrst_held", int'(held), 1);

        chk("press_and_multi_together", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
